// File: rtl/sdpram_xls_chan_pipelined.sv
// Semi-dual-port RAM behind XLS valid/ready channels: masked writes with credit-limited
// completion tokens, pipelined reads with a credit-checked in-order response FIFO.
module sdpram_xls_chan_pipelined #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned NUM_PARTITIONS = 4,
   parameter int unsigned RD_LATENCY     = 2,
   parameter int unsigned RESP_DEPTH     = 4,
   parameter int unsigned WR_RESP_MAX    = 4,
   parameter int unsigned RDW_NEW_DATA   = 1
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [ADDR_WIDTH+DATA_WIDTH+NUM_PARTITIONS-1:0] wr_req_data,
   input  logic                                           wr_req_vld,
   output logic                                           wr_req_rdy,
   output logic                                           wr_resp_vld,
   input  logic                                           wr_resp_rdy,
   input  logic [ADDR_WIDTH+NUM_PARTITIONS-1:0]            rd_req_data,
   input  logic                                           rd_req_vld,
   output logic                                           rd_req_rdy,
   output logic [DATA_WIDTH-1:0]                          rd_resp_data,
   output logic                                           rd_resp_vld,
   input  logic                                           rd_resp_rdy
);

   localparam int unsigned PW       = DATA_WIDTH / NUM_PARTITIONS;
   localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
   localparam int unsigned PtrW     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned FifoCntW = $clog2(RESP_DEPTH + 1);
   localparam int unsigned WrCntW   = $clog2(WR_RESP_MAX + 1);
   localparam int unsigned Stages   = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;

   logic [ADDR_WIDTH-1:0]     wr_addr;
   logic [DATA_WIDTH-1:0]     wr_data;
   logic [NUM_PARTITIONS-1:0] wr_mask;
   logic [ADDR_WIDTH-1:0]     rd_addr;
   logic                      unused_rd_mask;

   assign {wr_addr, wr_data, wr_mask} = wr_req_data;
   assign rd_addr        = rd_req_data[ADDR_WIDTH+NUM_PARTITIONS-1:NUM_PARTITIONS];
   assign unused_rd_mask = ^rd_req_data[NUM_PARTITIONS-1:0];

   // ---------------- write path ----------------
   logic              wr_xfer;
   logic              wr_resp_xfer;
   logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;

   assign wr_resp_vld  = (wr_cnt_q != '0);
   assign wr_resp_xfer = wr_resp_vld && wr_resp_rdy;
   assign wr_req_rdy   = (wr_cnt_q < WrCntW'(WR_RESP_MAX)) || wr_resp_xfer;
   assign wr_xfer      = wr_req_vld && wr_req_rdy;

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      if (wr_xfer && !wr_resp_xfer) begin
         wr_cnt_d = wr_cnt_q + WrCntW'(1);
      end else if (!wr_xfer && wr_resp_xfer) begin
         wr_cnt_d = wr_cnt_q - WrCntW'(1);
      end
   end

   logic [DATA_WIDTH-1:0] mem_q [Depth];

   // Storage is intentionally not reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_xfer) begin
         for (int i = 0; i < NUM_PARTITIONS; i++) begin
            if (wr_mask[i]) mem_q[wr_addr][i*PW +: PW] <= wr_data[i*PW +: PW];
         end
      end
   end

   // ---------------- read path ----------------
   logic                  rd_xfer;
   logic                  rd_resp_xfer;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  push;
   logic [DATA_WIDTH-1:0] push_data;
   logic [Stages-1:0]     pipe_vld_q;
   int unsigned           in_flight;

   always_comb begin
      rd_word = mem_q[rd_addr];
      if ((RDW_NEW_DATA != 0) && wr_xfer && (wr_addr == rd_addr)) begin
         for (int i = 0; i < NUM_PARTITIONS; i++) begin
            if (wr_mask[i]) rd_word[i*PW +: PW] = wr_data[i*PW +: PW];
         end
      end
   end

   if (RD_LATENCY > 1) begin : g_pipe
      logic [DATA_WIDTH-1:0] pipe_data_q [Stages];

      always_ff @(posedge clk) begin
         if (rst) begin
            pipe_vld_q <= '0;
         end else begin
            pipe_vld_q[0] <= rd_xfer;
            for (int i = 1; i < Stages; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         pipe_data_q[0] <= rd_word;
         for (int i = 1; i < Stages; i++) pipe_data_q[i] <= pipe_data_q[i-1];
      end

      assign push      = pipe_vld_q[Stages-1];
      assign push_data = pipe_data_q[Stages-1];
   end else begin : g_nopipe
      assign pipe_vld_q = '0;
      assign push       = rd_xfer;
      assign push_data  = rd_word;
   end

   logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];
   logic [PtrW-1:0]       wptr_q, wptr_d;
   logic [PtrW-1:0]       rptr_q, rptr_d;
   logic [FifoCntW-1:0]   fifo_cnt_q, fifo_cnt_d;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(RESP_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign rd_resp_vld  = (fifo_cnt_q != '0);
   assign rd_resp_data = fifo_q[rptr_q];
   assign rd_resp_xfer = rd_resp_vld && rd_resp_rdy;

   // Credits cover pipeline stages too, so a push always finds room in the FIFO.
   always_comb begin
      in_flight = 32'(fifo_cnt_q);
      for (int i = 0; i < Stages; i++) in_flight += 32'(pipe_vld_q[i]);
   end

   assign rd_req_rdy = (in_flight < RESP_DEPTH) || rd_resp_xfer;
   assign rd_xfer    = rd_req_vld && rd_req_rdy;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push)         wptr_d = ptr_inc(wptr_q);
      if (rd_resp_xfer) rptr_d = ptr_inc(rptr_q);
      if (push && !rd_resp_xfer) begin
         fifo_cnt_d = fifo_cnt_q + FifoCntW'(1);
      end else if (!push && rd_resp_xfer) begin
         fifo_cnt_d = fifo_cnt_q - FifoCntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q   <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         fifo_cnt_q <= '0;
      end else begin
         wr_cnt_q   <= wr_cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

endmodule

// File: tb/tb_sdpram_xls_chan_pipelined.sv
// Directed bench for sdpram_xls_chan_pipelined: vector table for write/read/RDW cases,
// hand sequences for read backpressure, write-credit limits and mid-flight reset.
module tb_sdpram_xls_chan_pipelined;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;
   localparam int unsigned NP = 4;
   localparam int unsigned RL = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [AW+DW+NP-1:0] wr_req_data;
   logic               wr_req_vld;
   logic               wr_req_rdy;
   logic               wr_resp_vld;
   logic               wr_resp_rdy;
   logic [AW+NP-1:0]   rd_req_data;
   logic               rd_req_vld;
   logic               rd_req_rdy;
   logic [DW-1:0]      rd_resp_data;
   logic               rd_resp_vld;
   logic               rd_resp_rdy;

   sdpram_xls_chan_pipelined dut (
      .clk          (clk),
      .rst          (rst),
      .wr_req_data  (wr_req_data),
      .wr_req_vld   (wr_req_vld),
      .wr_req_rdy   (wr_req_rdy),
      .wr_resp_vld  (wr_resp_vld),
      .wr_resp_rdy  (wr_resp_rdy),
      .rd_req_data  (rd_req_data),
      .rd_req_vld   (rd_req_vld),
      .rd_req_rdy   (rd_req_rdy),
      .rd_resp_data (rd_resp_data),
      .rd_resp_vld  (rd_resp_vld),
      .rd_resp_rdy  (rd_resp_rdy)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_err  = 0;
   int wr_tok = 0;

   always @(posedge clk) begin
      if (wr_resp_vld && wr_resp_rdy) wr_tok++;
   end

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   pre;
      logic [31:0]   wdata;
      logic [3:0]    wmask;
      logic          same;
      logic [31:0]   exp;
   } vec_t;

   vec_t vecs [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
      wr_req_data = {a, d, m};
      wr_req_vld  = 1'b1;
      step();
      wr_req_vld  = 1'b0;
   endtask

   // Returns cycles from read accept to rd_resp_vld (bounded).
   task automatic wait_resp(output int lat);
      lat = 1;
      while (!rd_resp_vld && lat < 12) begin
         step();
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int base;
      int lat;
      base        = wr_tok;
      wr_req_data = {v.addr, v.pre, 4'hF};
      wr_req_vld  = 1'b1;
      step();
      wr_req_data = {v.addr, v.wdata, v.wmask};
      if (!v.same) begin
         step();
         wr_req_vld = 1'b0;
      end
      rd_req_data = {v.addr, 4'h0};
      rd_req_vld  = 1'b1;
      step();
      wr_req_vld  = 1'b0;
      rd_req_vld  = 1'b0;
      wait_resp(lat);
      chk("vec_rd_latency", lat, RL);
      chk("vec_rd_data", rd_resp_data, v.exp);
      step();
      step();
      chk("vec_wr_tokens", wr_tok - base, 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int acc;
      int base;
      int lat;

      // addr, preload, wdata, wmask, same-cycle read, expected word
      vecs[0] = '{10'd5,   32'hDEADBEEF, 32'h01234567, 4'h0,    1'b0, 32'hDEADBEEF};
      vecs[1] = '{10'd7,   32'h11223344, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h11BB33DD};
      vecs[2] = '{10'd9,   32'h00000000, 32'hFFFFFFFF, 4'b0011, 1'b1, 32'h0000FFFF};
      vecs[3] = '{10'd9,   32'h12345678, 32'hCAFEF00D, 4'b1000, 1'b1, 32'hCA345678};
      vecs[4] = '{10'h3FF, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'hF,    1'b0, 32'h5A5A5A5A};
      vecs[5] = '{10'd0,   32'h00000000, 32'h0F0F0F0F, 4'b0110, 1'b1, 32'h000F0F00};

      rst         = 1'b1;
      wr_req_data = '0;
      wr_req_vld  = 1'b0;
      wr_resp_rdy = 1'b1;
      rd_req_data = '0;
      rd_req_vld  = 1'b0;
      rd_resp_rdy = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("reset_rd_resp_vld", rd_resp_vld, 0);
      chk("reset_wr_resp_vld", wr_resp_vld, 0);
      chk("reset_rd_req_rdy", rd_req_rdy, 1);
      chk("reset_wr_req_rdy", wr_req_rdy, 1);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Read backpressure: only RESP_DEPTH reads get in, then drain in order.
      for (int i = 0; i < 4; i++) wr(AW'(i), 32'h100 + i, 4'hF);
      repeat (3) step();
      rd_resp_rdy = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         rd_req_data = {AW'(i), 4'hF};
         rd_req_vld  = 1'b1;
         if (rd_req_rdy) acc++;
         step();
      end
      rd_req_vld = 1'b0;
      repeat (2) step();
      chk("bp_reads_accepted", acc, 4);
      chk("bp_rd_req_rdy_full", rd_req_rdy, 0);
      chk("bp_rd_resp_vld_full", rd_resp_vld, 1);
      rd_resp_rdy = 1'b1;
      #1;
      chk("bp_rd_req_rdy_bypass", rd_req_rdy, 1);
      for (int k = 0; k < 4; k++) begin
         chk("bp_drain_vld", rd_resp_vld, 1);
         chk("bp_drain_data", rd_resp_data, 32'h100 + k);
         step();
      end
      chk("bp_drain_empty", rd_resp_vld, 0);

      // Write credit limit and concurrent request/response transfer.
      base        = wr_tok;
      wr_resp_rdy = 1'b0;
      acc         = 0;
      for (int i = 0; i < 6; i++) begin
         wr_req_data = {AW'(32'h20 + i), 32'h0, 4'h0};
         wr_req_vld  = 1'b1;
         if (wr_req_rdy) acc++;
         step();
      end
      wr_req_vld = 1'b0;
      chk("wc_writes_accepted", acc, 4);
      chk("wc_wr_req_rdy_full", wr_req_rdy, 0);
      chk("wc_wr_resp_vld", wr_resp_vld, 1);
      wr_req_data = {AW'(32'h40), 32'h55, 4'hF};
      wr_req_vld  = 1'b1;
      wr_resp_rdy = 1'b1;
      #1;
      chk("wc_wr_req_rdy_bypass", wr_req_rdy, 1);
      step();
      wr_req_vld  = 1'b0;
      wr_resp_rdy = 1'b0;
      #1;
      chk("wc_concurrent_token", wr_tok - base, 1);
      chk("wc_still_full", wr_req_rdy, 0);
      wr_resp_rdy = 1'b1;
      repeat (6) step();
      chk("wc_total_tokens", wr_tok - base, 5);
      chk("wc_drained", wr_resp_vld, 0);

      // Reset with reads and write responses in flight.
      rd_resp_rdy = 1'b0;
      wr_resp_rdy = 1'b0;
      wr(AW'(32'h30), 32'h0, 4'h0);
      wr(AW'(32'h31), 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         rd_req_data = {AW'(i), 4'hF};
         rd_req_vld  = 1'b1;
         step();
      end
      rd_req_vld = 1'b0;
      rst        = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_rd_resp_vld", rd_resp_vld, 0);
      chk("rst_wr_resp_vld", wr_resp_vld, 0);
      chk("rst_rd_req_rdy", rd_req_rdy, 1);
      chk("rst_wr_req_rdy", wr_req_rdy, 1);
      rd_resp_rdy = 1'b1;
      wr_resp_rdy = 1'b1;
      rd_req_data = {AW'(5), 4'hF};
      rd_req_vld  = 1'b1;
      step();
      rd_req_vld = 1'b0;
      wait_resp(lat);
      chk("rst_retained_latency", lat, RL);
      chk("rst_retained_data", rd_resp_data, 32'hDEADBEEF);
      step();
      chk("rst_single_resp", rd_resp_vld, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
